// File: rtl/saturation_ext.sv
// rtl/saturation_ext.sv - RGB saturation filter, 5-stage pipeline, frame-synchronous coefficients
// Optional clipped-pixel counter enabled by SATURATION_CLIP_CNT_EN.
module saturation_ext #(
    parameter int PIXEL_WIDTH = 10,
    parameter int COE_WIDTH   = 16,
    parameter int COE_FRAC    = 6,
    parameter int DBG_WIDTH   = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [COE_WIDTH-1:0]     saturation_i,
    input  logic [COE_WIDTH-1:0]     ycoe0_i,
    input  logic [COE_WIDTH-1:0]     ycoe1_i,
    input  logic [COE_WIDTH-1:0]     ycoe2_i,
    input  logic                     bypass_i,
    input  logic [3*PIXEL_WIDTH-1:0] di_i,
    input  logic                     de_i,
    input  logic                     hs_i,
    input  logic                     vs_i,
    input  logic [DBG_WIDTH-1:0]     dbg_i,
    output logic [3*PIXEL_WIDTH-1:0] do_o,
    output logic                     de_o,
    output logic                     hs_o,
    output logic                     vs_o,
    output logic [DBG_WIDTH-1:0]     dbg_o,
    output logic                     upd_o,
    output logic [23:0]              clip_cnt_o
);
    localparam int PW     = PIXEL_WIDTH;
    localparam int PROD_W = COE_WIDTH + PW;
    localparam int SUM_W  = PROD_W + 2;
    localparam int Y_W    = SUM_W - COE_FRAC;
    localparam int D_W    = PW + 1;
    localparam int P_W    = D_W + COE_WIDTH + 1;
    localparam int O_W    = P_W + 1;
    localparam logic [PW-1:0]         PIX_MAX = '1;
    localparam logic [Y_W-1:0]        Y_MAX   = Y_W'((1 << PW) - 1);
    localparam logic signed [O_W-1:0] O_MAX   = O_W'((1 << PW) - 1);

    logic [COE_WIDTH-1:0] coe_in  [3];
    logic [COE_WIDTH-1:0] act_coe [3];
    logic [COE_WIDTH-1:0] act_sat;
    logic                 act_byp;
    logic                 vs_prev;
    logic                 load;

    assign coe_in[0] = ycoe0_i;
    assign coe_in[1] = ycoe1_i;
    assign coe_in[2] = ycoe2_i;
    assign load      = vs_i & ~vs_prev;

    // Active set swaps on the vs edge; the pixel sampled on that edge still sees the old set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) act_coe[i] <= '0;
            act_sat <= '0;
            act_byp <= 1'b0;
            vs_prev <= 1'b0;
            upd_o   <= 1'b0;
        end else begin
            vs_prev <= vs_i;
            upd_o   <= load;
            if (load) begin
                for (int i = 0; i < 3; i++) act_coe[i] <= coe_in[i];
                act_sat <= saturation_i;
                act_byp <= bypass_i;
            end
        end
    end

    // Side-band delay lines: raw pixel, per-pixel gain and bypass travel with the data.
    logic [3*PW-1:0]      pix_pipe [4];
    logic [COE_WIDTH-1:0] sat_pipe [3];
    logic                 byp_pipe [4];
    logic [2:0]           ctl_pipe [5];
    logic [DBG_WIDTH-1:0] dbg_pipe [5];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                pix_pipe[i] <= '0;
                byp_pipe[i] <= 1'b0;
            end
            for (int i = 0; i < 3; i++) sat_pipe[i] <= '0;
            for (int i = 0; i < 5; i++) begin
                ctl_pipe[i] <= '0;
                dbg_pipe[i] <= '0;
            end
        end else begin
            pix_pipe[0] <= di_i;
            byp_pipe[0] <= act_byp;
            sat_pipe[0] <= act_sat;
            ctl_pipe[0] <= {vs_i, hs_i, de_i};
            dbg_pipe[0] <= dbg_i;
            for (int i = 1; i < 4; i++) begin
                pix_pipe[i] <= pix_pipe[i-1];
                byp_pipe[i] <= byp_pipe[i-1];
            end
            for (int i = 1; i < 3; i++) sat_pipe[i] <= sat_pipe[i-1];
            for (int i = 1; i < 5; i++) begin
                ctl_pipe[i] <= ctl_pipe[i-1];
                dbg_pipe[i] <= dbg_pipe[i-1];
            end
        end
    end

    logic [PROD_W-1:0]       prod_s1 [3];
    logic [Y_W-1:0]          y_s2;
    logic [PW-1:0]           y_s3;
    logic signed [D_W-1:0]   d_s3 [3];
    logic [PW-1:0]           y_s4;
    logic signed [P_W-1:0]   p_s4 [3];

    logic [SUM_W-1:0]        sum_s1;
    logic [PW-1:0]           y_clamp;
    logic signed [P_W-1:0]   p_sh  [3];
    logic signed [O_W-1:0]   o_sum [3];
    logic [PW-1:0]           o_ch  [3];
`ifdef SATURATION_CLIP_CNT_EN
    logic                    clip_raw;
    logic                    clip_any;
`endif

    assign sum_s1  = SUM_W'(prod_s1[0]) + SUM_W'(prod_s1[1]) + SUM_W'(prod_s1[2]);
    assign y_clamp = (y_s2 > Y_MAX) ? PIX_MAX : y_s2[PW-1:0];

    always_comb begin
`ifdef SATURATION_CLIP_CNT_EN
        clip_raw = 1'b0;
`endif
        for (int c = 0; c < 3; c++) begin
            p_sh[c]  = p_s4[c] >>> COE_FRAC;
            o_sum[c] = O_W'($signed({1'b0, y_s4})) + O_W'(p_sh[c]);
            o_ch[c]  = o_sum[c][PW-1:0];
            if (o_sum[c] < 0) begin
                o_ch[c] = '0;
`ifdef SATURATION_CLIP_CNT_EN
                clip_raw = 1'b1;
`endif
            end else if (o_sum[c] > O_MAX) begin
                o_ch[c] = PIX_MAX;
`ifdef SATURATION_CLIP_CNT_EN
                clip_raw = 1'b1;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < 3; c++) begin
                prod_s1[c] <= '0;
                d_s3[c]    <= '0;
                p_s4[c]    <= '0;
            end
            y_s2 <= '0;
            y_s3 <= '0;
            y_s4 <= '0;
            do_o <= '0;
        end else begin
            for (int c = 0; c < 3; c++) begin
                prod_s1[c] <= PROD_W'(act_coe[c]) * PROD_W'(di_i[c*PW +: PW]);
                d_s3[c]    <= $signed({1'b0, pix_pipe[1][c*PW +: PW]}) - $signed({1'b0, y_clamp});
                p_s4[c]    <= P_W'(d_s3[c]) * P_W'($signed({1'b0, sat_pipe[2]}));
            end
            y_s2 <= Y_W'(sum_s1 >> COE_FRAC);
            y_s3 <= y_clamp;
            y_s4 <= y_s3;
            do_o <= byp_pipe[3] ? pix_pipe[3] : {o_ch[2], o_ch[1], o_ch[0]};
        end
    end

    assign de_o  = ctl_pipe[4][0];
    assign hs_o  = ctl_pipe[4][1];
    assign vs_o  = ctl_pipe[4][2];
    assign dbg_o = dbg_pipe[4];

`ifdef SATURATION_CLIP_CNT_EN
    logic [23:0] clip_cnt;
    logic        vs_rise5;

    assign clip_any = clip_raw & ctl_pipe[3][0] & ~byp_pipe[3];
    assign vs_rise5 = ctl_pipe[3][2] & ~ctl_pipe[4][2];

    // A clipped pixel on the frame-boundary cycle belongs to the new frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clip_cnt   <= '0;
            clip_cnt_o <= '0;
        end else if (vs_rise5) begin
            clip_cnt_o <= clip_cnt;
            clip_cnt   <= {23'd0, clip_any};
        end else if (clip_any && (clip_cnt != 24'hFF_FFFF)) begin
            clip_cnt <= clip_cnt + 24'd1;
        end
    end
`else
    assign clip_cnt_o = '0;
`endif

endmodule

// File: tb/tb_saturation_ext.sv
// tb/tb_saturation_ext.sv - randomized bench for saturation_ext against an arithmetic reference model
module tb_saturation_ext;
    localparam int PW    = 10;
    localparam int UNITY = 64;
    localparam int PMAX  = 1023;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] saturation_i = '0;
    logic [15:0] ycoe0_i = '0;
    logic [15:0] ycoe1_i = '0;
    logic [15:0] ycoe2_i = '0;
    logic        bypass_i = 1'b0;
    logic [29:0] di_i = '0;
    logic        de_i = 1'b0;
    logic        hs_i = 1'b0;
    logic        vs_i = 1'b0;
    logic [15:0] dbg_i = '0;
    logic [29:0] do_o;
    logic        de_o, hs_o, vs_o, upd_o;
    logic [15:0] dbg_o;
    logic [23:0] clip_cnt_o;

    saturation_ext dut (
        .clk(clk), .rst_n(rst_n), .saturation_i(saturation_i),
        .ycoe0_i(ycoe0_i), .ycoe1_i(ycoe1_i), .ycoe2_i(ycoe2_i),
        .bypass_i(bypass_i), .di_i(di_i), .de_i(de_i), .hs_i(hs_i), .vs_i(vs_i),
        .dbg_i(dbg_i), .do_o(do_o), .de_o(de_o), .hs_o(hs_o), .vs_o(vs_o),
        .dbg_o(dbg_o), .upd_o(upd_o), .clip_cnt_o(clip_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [29:0] pix;
        logic        de;
        logic        hs;
        logic        vs;
        logic [15:0] dbg;
        logic        clip;
    } exp_t;

    exp_t        exp_q[$];
    int          m_sat, m_coe0, m_coe1, m_coe2;
    bit          m_byp, m_vs_prev, m_vs5_prev;
    int unsigned m_cnt, m_cnt_out;
    int          vectors = 0;
    int          miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic longint floor_div(input longint a, input longint b);
        longint q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    function automatic logic [29:0] model_pix(input logic [29:0] p, output bit clip);
        longint      ch[3];
        longint      y, o;
        logic [29:0] res;
        clip = 1'b0;
        res  = '0;
        if (m_byp) return p;
        for (int i = 0; i < 3; i++) ch[i] = longint'(p[i*PW +: PW]);
        y = (longint'(m_coe0) * ch[0] + longint'(m_coe1) * ch[1] + longint'(m_coe2) * ch[2]) / UNITY;
        if (y > PMAX) y = PMAX;
        for (int i = 0; i < 3; i++) begin
            o = y + floor_div((ch[i] - y) * longint'(m_sat), UNITY);
            if (o < 0) begin
                o = 0;
                clip = 1'b1;
            end else if (o > PMAX) begin
                o = PMAX;
                clip = 1'b1;
            end
            res[i*PW +: PW] = o[PW-1:0];
        end
        return res;
    endfunction

    task automatic reset_model();
        exp_t z;
        z = '0;
        exp_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back(z);
        m_sat = 0; m_coe0 = 0; m_coe1 = 0; m_coe2 = 0;
        m_byp = 1'b0; m_vs_prev = 1'b0; m_vs5_prev = 1'b0;
        m_cnt = 0; m_cnt_out = 0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_do"}, do_o, 0);
        chk({tag, "_strobes"}, {de_o, hs_o, vs_o, upd_o}, 0);
        chk({tag, "_dbg"}, dbg_o, 0);
        chk({tag, "_clip_cnt"}, clip_cnt_o, 0);
    endtask

    task automatic step();
        exp_t e, f;
        bit   clip, ld;
        @(posedge clk);
        if (!rst_n) begin
            reset_model();
            #1;
            chk_zero("rst");
            return;
        end
        ld     = vs_i && !m_vs_prev;
        e.pix  = model_pix(di_i, clip);
        e.de   = de_i;
        e.hs   = hs_i;
        e.vs   = vs_i;
        e.dbg  = dbg_i;
        e.clip = clip && de_i;
        exp_q.push_back(e);
        if (ld) begin
            m_sat = int'(saturation_i);
            m_coe0 = int'(ycoe0_i); m_coe1 = int'(ycoe1_i); m_coe2 = int'(ycoe2_i);
            m_byp = bypass_i;
        end
        m_vs_prev = vs_i;
        #1;
        chk("upd", upd_o, ld);
        f = exp_q.pop_front();
        chk("do", do_o, f.pix);
        chk("de_hs_vs", {de_o, hs_o, vs_o}, {f.de, f.hs, f.vs});
        chk("dbg", dbg_o, f.dbg);
`ifdef SATURATION_CLIP_CNT_EN
        if (f.vs && !m_vs5_prev) begin
            m_cnt_out = m_cnt;
            m_cnt = f.clip ? 1 : 0;
        end else if (f.clip && m_cnt < 24'hFF_FFFF) begin
            m_cnt++;
        end
        m_vs5_prev = f.vs;
        chk("clip_cnt", clip_cnt_o, m_cnt_out);
`else
        chk("clip_cnt", clip_cnt_o, 0);
`endif
    endtask

    task automatic rand_pix(input int fixed_pix);
        di_i  = (fixed_pix < 0) ? 30'($urandom) : 30'(fixed_pix);
        de_i  = 1'($urandom);
        hs_i  = 1'($urandom);
        dbg_i = 16'($urandom);
    endtask

    task automatic frame(input int sat, input int c0, input int c1, input int c2,
                         input bit byp, input int npix, input int fixed_pix);
        saturation_i = 16'(sat);
        ycoe0_i = 16'(c0); ycoe1_i = 16'(c1); ycoe2_i = 16'(c2);
        bypass_i = byp;
        vs_i = 1'b1;
        rand_pix(-1);
        step();
        rand_pix(fixed_pix);
        step();
        vs_i = 1'b0;
        for (int i = 0; i < npix; i++) begin
            rand_pix(fixed_pix);
            if (i == npix / 2) begin
                saturation_i = 16'($urandom);
                ycoe0_i = 16'($urandom); ycoe1_i = 16'($urandom); ycoe2_i = 16'($urandom);
                bypass_i = 1'($urandom);
            end
            step();
        end
    endtask

    initial begin
        reset_model();
        for (int i = 0; i < 3; i++) step();
        rst_n = 1'b1;

        // Before the first vs edge every coefficient is zero.
        for (int i = 0; i < 8; i++) begin
            rand_pix(-1);
            saturation_i = 16'($urandom);
            ycoe0_i = 16'($urandom);
            step();
        end
        chk("pre_vs_zero", do_o, 0);

        frame(64, 19, 37, 9, 1'b0, 40, -1);
        frame(0, 19, 37, 9, 1'b0, 10, {10'd100, 10'd100, 10'd100});
        chk("sat0_grey", do_o, {10'd101, 10'd101, 10'd101});
        frame(128, 19, 37, 9, 1'b0, 10, {10'd0, 10'd0, 10'd1023});
        chk("sat128_red", do_o, {10'd0, 10'd0, 10'd1023});
        frame(64, 19, 37, 9, 1'b0, 10, {10'd1023, 10'd1023, 10'd1023});
        chk("white_clamp", do_o, {10'd1023, 10'd1023, 10'd1023});

        for (int f = 0; f < 6; f++)
            frame($urandom_range(0, 255), $urandom_range(0, 48), $urandom_range(0, 48),
                  $urandom_range(0, 48), ($urandom_range(0, 3) == 0), $urandom_range(8, 30), -1);
        frame($urandom_range(0, 65535), $urandom_range(0, 65535), $urandom_range(0, 65535),
              $urandom_range(0, 65535), 1'b0, 20, -1);

        // Bypass frame interrupted by a mid-frame reset.
        frame(64, 19, 37, 9, 1'b1, 12, -1);
        #2 rst_n = 1'b0;
        #1 chk_zero("async_rst");
        for (int i = 0; i < 3; i++) step();
        rst_n = 1'b1;
        vs_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            rand_pix(-1);
            step();
        end
        chk("post_rst_no_bypass", do_o, 0);

        frame(64, 19, 37, 9, 1'b0, 20, -1);
        frame($urandom_range(0, 255), $urandom_range(0, 64), $urandom_range(0, 64),
              $urandom_range(0, 64), 1'b0, 20, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/saturation_ext.md
Name: saturation_ext

Overview:
- Parametrised next-generation RGB saturation filter for the video filter chain.
- Computes luma Y from per-channel coefficients, then scales each channel's distance from Y by a saturation gain.
- Generalised pixel width, coefficient width and fractional precision; frame-synchronous coefficient shadowing; bypass mode.
- Fixed-latency pipeline carrying de/hs/vs and a debug tag alongside the data.

Parameters:
- PIXEL_WIDTH, 10, bits per colour channel (8..12).
- COE_WIDTH, 16, bits per unsigned coefficient (saturation and luma).
- COE_FRAC, 6, fractional bits of all coefficients; unity gain = 2**COE_FRAC.
- DBG_WIDTH, 16, width of the debug tag passed through the pipeline.

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- saturation_i  in  COE_WIDTH  saturation gain, unsigned, COE_FRAC fraction bits
- ycoe0_i  in  COE_WIDTH  luma coefficient for R
- ycoe1_i  in  COE_WIDTH  luma coefficient for G
- ycoe2_i  in  COE_WIDTH  luma coefficient for B
- bypass_i  in  1  1 = pass pixels unmodified
- di_i  in  3*PIXEL_WIDTH  pixel {B,G,R}, R in LSBs
- de_i / hs_i / vs_i  in  1 each  video strobes
- dbg_i  in  DBG_WIDTH  tag aligned with di_i
- do_o  out  3*PIXEL_WIDTH  processed pixel {B,G,R}
- de_o / hs_o / vs_o  out  1 each  strobes delayed by the pipeline latency
- dbg_o  out  DBG_WIDTH  tag delayed by the pipeline latency
- upd_o  out  1  one-cycle pulse when the active coefficient set reloads
- clip_cnt_o  out  24  clipped-pixel count of the previous frame (optional feature only)

Behaviour:
- Reset: all outputs 0; pipeline and strobe delay lines cleared; active coefficient set and bypass cleared; vs edge detector cleared.
- Asserting reset mid-frame discards every in-flight pixel; no partial outputs after release.
- Active set {saturation, ycoe0..2, bypass} loads from the inputs when vs_i rises (vs_i=1 this cycle, 0 last cycle).
- Any pixel sampled in that same cycle uses the OLD set; the new set applies from the next cycle.
- upd_o pulses 1 cycle after the load edge.
- Inputs are ignored at all other times, so coefficient changes never tear a frame.
- Until the first vs_i rising edge after reset, all coefficients are 0, so every output pixel is 0.
- Latency is exactly 5 clk cycles for data, de, hs, vs and dbg, independent of de_i and bypass.
- Pixels with de_i=0 still propagate; no flow control, no stalls.
- Pipeline stages:
  - S1: register products ycoe0*R, ycoe1*G, ycoe2*B.
  - S2: sum; Y = sum >> COE_FRAC.
  - S3: clamp Y to [0, 2**PIXEL_WIDTH-1]; signed diff Dx = x - Y per channel.
  - S4: Px = Dx * saturation (signed).
  - S5: Ox = Y + (Px >>> COE_FRAC), arithmetic shift (floor toward -inf); clamp to [0, 2**PIXEL_WIDTH-1]; register to do_o.
- Widths: every intermediate is wide enough that no wrap-around occurs for any input; only the explicit clamps limit values.
- Bypass: do_o equals di_i delayed by 5 cycles, bit-exact.
- A sum of luma coefficients above unity is legal; Y clamps.
- Saturation=unity gives do_o == di_i exactly.

Optional Feature:
- Macro: SATURATION_CLIP_CNT_EN.
- Defined:
  - A 24-bit counter increments for each S5 pixel with de=1 where any channel clamps (high or low); counting is inhibited in bypass.
  - The counter saturates at 2**24-1.
  - On the S5-aligned vs rising edge, clip_cnt_o takes the counter value and the counter restarts from 0; a clipped pixel in that same cycle counts toward the new frame.
- Undefined: no counter logic; clip_cnt_o tied to 0.

Test Plan:
- Defaults; ycoe=19/37/9; saturation=64; one vs pulse, then random pixels -> do_o == di_i five cycles later; de/hs/vs/dbg aligned.
- saturation=0; pixel R=G=B=100 -> Y=6500>>6=101; do_o={101,101,101}.
- saturation=128; pixel R=1023, G=0, B=0 -> Y=303, R clamps to 1023, G=B=0. With the macro, the next frame's clip_cnt_o=1.
- Pixel R=G=B=1023, saturation=64 -> Y sum 1038 clamps to 1023; output {1023,1023,1023}.
- Change saturation_i from 64 to 0 mid-frame -> output unchanged until the next vs_i rise; upd_o pulses 1 cycle later; the pixel sampled on the edge cycle still uses 64.
- bypass_i=1 latched at vs; then rst_n low for 3 cycles mid-frame -> all outputs 0 immediately; after release, no stale data; bypass cleared until the next vs.
